add_alu: RTL and testbench



---
 rtl/alu_pkg.sv | 16 +
 rtl/add_alu_core.sv | 49 ++++
 rtl/add_alu.sv | 39 +++
 tb/tb_add_alu.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode definitions for the add_alu datapath.
package alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  typedef enum logic [1:0] {
    ALU_AND = OP_AND,
    ALU_SUB = OP_SUB,
    ALU_ADD = OP_ADD,
    ALU_MUL = OP_MUL
  } alu_op_e;

endpackage

// File: rtl/add_alu_core.sv
// Combinational next-result and flag compute for add_alu; no state.
module add_alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  alu_op_e            op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] res,
  output logic               c
);

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff;
  logic               borrow;
  logic [2*WIDTH-1:0] prod;

  assign sum    = {1'b0, a} + {1'b0, b};
  assign diff   = a - b;
  assign borrow = (a < b);
  // Widen both operands first so the product keeps every bit.
  assign prod   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  always_comb begin
    res = '0;
    c   = 1'b0;
    case (op)
      ALU_AND: res = {{WIDTH{1'b0}}, a & b};
      ALU_SUB: begin
        res = {{WIDTH{1'b0}}, diff};
        c   = borrow;
      end
      ALU_ADD: begin
        res = {{(WIDTH-1){1'b0}}, sum};
        c   = sum[WIDTH];
      end
      ALU_MUL: begin
        res = prod;
        c   = |prod[2*WIDTH-1:WIDTH];
      end
      default: begin
        res = '0;
        c   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/add_alu.sv
// Registered add/sub/and/mul unit: enable-gated output register around add_alu_core.
module add_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] Doutadd,
  output logic               C
);

  logic [2*WIDTH-1:0] res_p0;
  logic               c_p0;

  add_alu_core #(.WIDTH(WIDTH)) u_core (
    .op  (alu_op_e'(op)),
    .a   (A),
    .b   (B),
    .res (res_p0),
    .c   (c_p0)
  );

  // p0 -> p1: result register, held while en is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Doutadd <= '0;
      C       <= 1'b0;
    end else if (en) begin
      Doutadd <= res_p0;
      C       <= c_p0;
    end
  end

endmodule

// File: tb/tb_add_alu.sv
// Directed self-checking bench for add_alu at WIDTH=3.
module tb_add_alu;

  localparam int W = 3;

  logic           clk;
  logic           rst_n;
  logic           en;
  logic [1:0]     op;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic [2*W-1:0] Doutadd;
  logic           C;

  int n_checks;
  int n_fail;

  add_alu #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .op      (op),
    .A       (A),
    .B       (B),
    .Doutadd (Doutadd),
    .C       (C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one enabled operation mid-cycle, then step past the capturing edge.
  task automatic apply(input int a, input int b, input logic [1:0] o);
    @(negedge clk);
    A  = W'(a);
    B  = W'(b);
    op = o;
    en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b0; op = 2'b00; A = '0; B = '0;
    #3;
    n_checks++;
    if (Doutadd !== 6'd0 || C !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: got %0d/%0b, want 0/0", Doutadd, C);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(7, 7, 2'b10);
    n_checks++;
    if (Doutadd !== 6'd14 || C !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_preload: got %0d/%0b, want 14/1", Doutadd, C);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (Doutadd !== 6'd0 || C !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got %0d/%0b, want 0/0", Doutadd, C);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (Doutadd !== 6'd0 || C !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_over_en: got %0d/%0b, want 0/0", Doutadd, C);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(1, 0, 2'b10);
    n_checks++;
    if (Doutadd !== 6'd1 || C !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_capture: got %0d/%0b, want 1/0", Doutadd, C);
    end
  endtask

  task automatic test_add();
    int ta[7] = '{1, 3, 3, 6, 6, 7, 7};
    int tb[7] = '{1, 1, 3, 3, 6, 6, 7};
    int te[7] = '{2, 4, 6, 9, 12, 13, 14};
    int tc[7] = '{0, 0, 0, 1, 1, 1, 1};
    for (int i = 0; i < 7; i++) begin
      apply(ta[i], tb[i], 2'b10);
      n_checks++;
      if (Doutadd !== 6'(te[i]) || C !== 1'(tc[i])) begin
        n_fail++;
        $display("FAIL add_%0d_%0d: got %0d/%0b, want %0d/%0d",
                 ta[i], tb[i], Doutadd, C, te[i], tc[i]);
      end
    end
  endtask

  task automatic test_hold();
    apply(3, 3, 2'b10);
    n_checks++;
    if (Doutadd !== 6'd6 || C !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_setup: got %0d/%0b, want 6/0", Doutadd, C);
    end
    @(negedge clk);
    en = 1'b0; A = 3'd7; B = 3'd7; op = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (Doutadd !== 6'd6 || C !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got %0d/%0b, want 6/0", i, Doutadd, C);
      end
    end
    apply(7, 7, 2'b11);
    n_checks++;
    if (Doutadd !== 6'd49 || C !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release_mul: got %0d/%0b, want 49/1", Doutadd, C);
    end
  endtask

  task automatic test_sub();
    int ta[4] = '{5, 2, 4, 0};
    int tb[4] = '{2, 5, 4, 1};
    int te[4] = '{3, 5, 0, 7};
    int tc[4] = '{0, 1, 0, 1};
    for (int i = 0; i < 4; i++) begin
      apply(ta[i], tb[i], 2'b01);
      n_checks++;
      if (Doutadd !== 6'(te[i]) || C !== 1'(tc[i])) begin
        n_fail++;
        $display("FAIL sub_%0d_%0d: got %0d/%0b, want %0d/%0d",
                 ta[i], tb[i], Doutadd, C, te[i], tc[i]);
      end
    end
  endtask

  task automatic test_and_mul();
    logic [1:0] to[5] = '{2'b00, 2'b11, 2'b11, 2'b11, 2'b00};
    int ta[5] = '{6, 2, 3, 0, 7};
    int tb[5] = '{3, 3, 3, 7, 5};
    int te[5] = '{2, 6, 9, 0, 5};
    int tc[5] = '{0, 0, 1, 0, 0};
    for (int i = 0; i < 5; i++) begin
      apply(ta[i], tb[i], to[i]);
      n_checks++;
      if (Doutadd !== 6'(te[i]) || C !== 1'(tc[i])) begin
        n_fail++;
        $display("FAIL op%0b_%0d_%0d: got %0d/%0b, want %0d/%0d",
                 to[i], ta[i], tb[i], Doutadd, C, te[i], tc[i]);
      end
    end
  endtask

  task automatic test_latency();
    apply(2, 3, 2'b10);
    n_checks++;
    if (Doutadd !== 6'd5 || C !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_first: got %0d/%0b, want 5/0", Doutadd, C);
    end
    @(negedge clk);
    A = 3'd4;
    #1;
    n_checks++;
    if (Doutadd !== 6'd5) begin
      n_fail++;
      $display("FAIL lat_no_comb_path: got %0d, want 5", Doutadd);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (Doutadd !== 6'd7 || C !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_next_edge: got %0d/%0b, want 7/0", Doutadd, C);
    end
    apply(7, 7, 2'b10);
    apply(0, 0, 2'b10);
    n_checks++;
    if (Doutadd !== 6'd0 || C !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_back_to_back: got %0d/%0b, want 0/0", Doutadd, C);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_add();
    test_hold();
    test_sub();
    test_and_mul();
    test_latency();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
